// File: rtl/frontend_sweep_controller.sv
// Steps the frontend DCO phase increment through START_INC + k*STEP_INC, settles,
// captures the SIN/COS mul-acc pair per point and offers it on a valid/ready port.
module frontend_sweep_controller #(
    parameter int PHASE_INCREMENT_BITS = 28,
    parameter int RESULT_MUL_ACC_WIDTH = 36,
    parameter int SETTLE_BITS          = 16,
    parameter int STEP_COUNT_BITS      = 10
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic                                   CE,
    input  logic                                   START,
    input  logic                                   ABORT,
    input  logic        [PHASE_INCREMENT_BITS-1:0] START_INC,
    input  logic        [PHASE_INCREMENT_BITS-1:0] STEP_INC,
    input  logic        [STEP_COUNT_BITS-1:0]      STEP_COUNT,
    input  logic        [SETTLE_BITS-1:0]          SETTLE_CYCLES,
    output logic        [PHASE_INCREMENT_BITS-1:0] PHASE_INCREMENT_OUT,
    output logic                                   PHASE_INCREMENT_WE,
    input  logic signed [RESULT_MUL_ACC_WIDTH-1:0] SIN_MUL_ACC,
    input  logic signed [RESULT_MUL_ACC_WIDTH-1:0] COS_MUL_ACC,
    output logic                                   RESULT_VALID,
    input  logic                                   RESULT_READY,
    output logic signed [RESULT_MUL_ACC_WIDTH-1:0] RESULT_SIN,
    output logic signed [RESULT_MUL_ACC_WIDTH-1:0] RESULT_COS,
    output logic        [PHASE_INCREMENT_BITS-1:0] RESULT_INC,
    output logic        [STEP_COUNT_BITS-1:0]      RESULT_INDEX,
    output logic                                   BUSY,
    output logic                                   DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic [PHASE_INCREMENT_BITS-1:0] inc_q, step_q, inc_next;
    logic [STEP_COUNT_BITS-1:0]      count_q, idx_q;
    logic [SETTLE_BITS-1:0]          settle_q, settle_cnt;
    logic                            start_ok, handshake, last_pt, abort_hit;

    always_comb begin
        start_ok  = START && (STEP_COUNT != '0);
        handshake = (state == S_OUTPUT) && RESULT_READY;
        last_pt   = (idx_q == count_q - STEP_COUNT_BITS'(1));
        abort_hit = ABORT && (state != S_IDLE);
        inc_next  = inc_q + step_q;

        state_nxt = state;
        case (state)
            S_IDLE:    if (start_ok) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = (settle_q == '0) ? S_CAPTURE : S_SETTLE;
            S_SETTLE:  if (settle_cnt == SETTLE_BITS'(1)) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_OUTPUT;
            S_OUTPUT:  if (handshake) state_nxt = last_pt ? S_IDLE : S_LOAD;
            default:   state_nxt = S_IDLE;
        endcase
        // Abort wins over a coincident handshake: that result is dropped.
        if (abort_hit) state_nxt = S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else if (CE) state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            inc_q               <= '0;
            step_q              <= '0;
            count_q             <= '0;
            idx_q               <= '0;
            settle_q            <= '0;
            settle_cnt          <= '0;
            PHASE_INCREMENT_OUT <= '0;
            PHASE_INCREMENT_WE  <= 1'b0;
            RESULT_VALID        <= 1'b0;
            RESULT_SIN          <= '0;
            RESULT_COS          <= '0;
            RESULT_INC          <= '0;
            RESULT_INDEX        <= '0;
            BUSY                <= 1'b0;
            DONE                <= 1'b0;
        end else begin
            // Strobes are single-cycle and never survive a CE-low cycle.
            PHASE_INCREMENT_WE <= 1'b0;
            DONE               <= 1'b0;
            if (CE) begin
                BUSY         <= (state_nxt != S_IDLE);
                RESULT_VALID <= (state_nxt == S_OUTPUT);
                DONE         <= handshake && last_pt && !abort_hit;
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            inc_q               <= START_INC;
                            step_q              <= STEP_INC;
                            count_q             <= STEP_COUNT;
                            settle_q            <= SETTLE_CYCLES;
                            idx_q               <= '0;
                            PHASE_INCREMENT_OUT <= START_INC;
                            PHASE_INCREMENT_WE  <= 1'b1;
                        end
                    end
                    S_LOAD:   settle_cnt <= settle_q;
                    S_SETTLE: settle_cnt <= settle_cnt - SETTLE_BITS'(1);
                    S_CAPTURE: begin
                        RESULT_SIN   <= SIN_MUL_ACC;
                        RESULT_COS   <= COS_MUL_ACC;
                        RESULT_INC   <= inc_q;
                        RESULT_INDEX <= idx_q;
                    end
                    S_OUTPUT: begin
                        if (handshake && !last_pt && !abort_hit) begin
                            idx_q               <= idx_q + STEP_COUNT_BITS'(1);
                            inc_q               <= inc_next;
                            PHASE_INCREMENT_OUT <= inc_next;
                            PHASE_INCREMENT_WE  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frontend_sweep_controller.sv
// Directed + randomized bench for frontend_sweep_controller; expected events come from
// a CE-cycle-counting model of the sweep rules applied to recorded input histories.
module tb_frontend_sweep_controller;

    logic               CLK, RESET, CE, START, ABORT;
    logic        [27:0] START_INC, STEP_INC, PHASE_INCREMENT_OUT, RESULT_INC;
    logic        [9:0]  STEP_COUNT, RESULT_INDEX;
    logic        [15:0] SETTLE_CYCLES;
    logic signed [35:0] SIN_MUL_ACC, COS_MUL_ACC, RESULT_SIN, RESULT_COS;
    logic               PHASE_INCREMENT_WE, RESULT_VALID, RESULT_READY, BUSY, DONE;

    frontend_sweep_controller dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .START(START), .ABORT(ABORT),
        .START_INC(START_INC), .STEP_INC(STEP_INC), .STEP_COUNT(STEP_COUNT),
        .SETTLE_CYCLES(SETTLE_CYCLES), .PHASE_INCREMENT_OUT(PHASE_INCREMENT_OUT),
        .PHASE_INCREMENT_WE(PHASE_INCREMENT_WE), .SIN_MUL_ACC(SIN_MUL_ACC),
        .COS_MUL_ACC(COS_MUL_ACC), .RESULT_VALID(RESULT_VALID), .RESULT_READY(RESULT_READY),
        .RESULT_SIN(RESULT_SIN), .RESULT_COS(RESULT_COS), .RESULT_INC(RESULT_INC),
        .RESULT_INDEX(RESULT_INDEX), .BUSY(BUSY), .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0, bad = 0, cyc = 0;
    int ce_mode = 0, rdy_mode = 0, lo_cnt = 0;
    bit force_ce = 0, scramble = 0;

    bit                 ce_hist[int], rdy_hist[int], busy_hist[int];
    logic signed [35:0] sin_hist[int], cos_hist[int];

    int                 we_c[$], hs_c[$], done_c[$];
    logic        [27:0] we_v[$], hs_inc[$];
    logic        [9:0]  hs_idx[$];
    logic signed [35:0] hs_sin[$], hs_cos[$];

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_ctl"}, {PHASE_INCREMENT_OUT, PHASE_INCREMENT_WE, RESULT_VALID, BUSY, DONE,
                             RESULT_INC, RESULT_INDEX}, '0);
        chk({tag, "_res"}, {RESULT_SIN, RESULT_COS}, '0);
    endtask

    // One clock: choose inputs for the coming edge, record them, step, log DUT events.
    task automatic tick();
        logic [109:0] pf;
        bit           hs, pv;
        case (ce_mode)
            0:       CE = 1'b1;
            1:       CE = !CE;
            default: CE = 1'($urandom_range(0, 1));
        endcase
        if (force_ce) CE = 1'b1;
        case (rdy_mode)
            0: RESULT_READY = 1'b1;
            1: RESULT_READY = 1'($urandom_range(0, 1));
            2: begin
                RESULT_READY = !(RESULT_VALID && RESULT_INDEX == 10'd1 && lo_cnt < 20);
                if (!RESULT_READY) lo_cnt++;
            end
            default: RESULT_READY = 1'b0;
        endcase
        if (scramble) begin
            START         = 1'($urandom_range(0, 1));
            START_INC     = 28'($urandom);
            STEP_INC      = 28'($urandom);
            STEP_COUNT    = 10'($urandom_range(0, 5));
            SETTLE_CYCLES = 16'($urandom_range(0, 9));
        end
        SIN_MUL_ACC = $signed(36'({$urandom, $urandom}));
        COS_MUL_ACC = $signed(36'({$urandom, $urandom}));
        ce_hist[cyc+1]  = CE;
        rdy_hist[cyc+1] = RESULT_READY;
        sin_hist[cyc+1] = SIN_MUL_ACC;
        cos_hist[cyc+1] = COS_MUL_ACC;
        hs = RESULT_VALID && RESULT_READY && CE && !ABORT && !RESET;
        pv = RESULT_VALID && !RESET;
        pf = {RESULT_SIN, RESULT_COS, RESULT_INC, RESULT_INDEX};
        @(posedge CLK);
        #1;
        cyc++;
        if (hs) begin
            hs_c.push_back(cyc);
            hs_sin.push_back($signed(pf[109:74]));
            hs_cos.push_back($signed(pf[73:38]));
            hs_inc.push_back(pf[37:10]);
            hs_idx.push_back(pf[9:0]);
        end
        if (PHASE_INCREMENT_WE) begin
            we_c.push_back(cyc);
            we_v.push_back(PHASE_INCREMENT_OUT);
        end
        if (DONE) done_c.push_back(cyc);
        busy_hist[cyc] = BUSY;
        if (pv && RESULT_VALID && !hs)
            chk("result_stable", {RESULT_SIN, RESULT_COS, RESULT_INC, RESULT_INDEX}, pf);
    endtask

    function automatic int next_ce(int e);
        int x = e + 1;
        while (!ce_hist[x] && x <= cyc) x++;
        return x;
    endfunction

    task automatic start_sweep(logic [27:0] si, logic [27:0] st, int n, int s, output int t);
        we_c.delete(); we_v.delete(); hs_c.delete(); hs_sin.delete(); hs_cos.delete();
        hs_inc.delete(); hs_idx.delete(); done_c.delete();
        lo_cnt = 0; scramble = 0;
        START_INC = si; STEP_INC = st; STEP_COUNT = 10'(n); SETTLE_CYCLES = 16'(s);
        START = 1'b1; force_ce = 1'b1;
        tick();
        force_ce = 1'b0; START = 1'b0;
        t = cyc;
    endtask

    // Reference: LOAD takes 1 CE cycle, SETTLE s, CAPTURE 1, then the first CE edge with
    // READY high is the handshake; the next WE (or DONE) appears right after it.
    task automatic check_sweep(int t, logic [27:0] si, logic [27:0] st, int n, int s);
        int          e = t, cap;
        logic [27:0] v;
        bit          busy_ok = 1;
        for (int k = 0; k < n; k++) begin
            v = 28'(si + st * 28'(k));
            if (k >= we_c.size()) begin chk("we_count", we_c.size(), n); break; end
            chk("we_cycle", we_c[k], e);
            chk("we_value", we_v[k], v);
            for (int j = 0; j < s + 2; j++) e = next_ce(e);
            cap = e;
            do e = next_ce(e); while (!rdy_hist[e] && e <= cyc);
            if (k >= hs_c.size()) begin chk("hs_count", hs_c.size(), n); break; end
            chk("hs_cycle", hs_c[k], e);
            chk("hs_index", hs_idx[k], k);
            chk("hs_inc", hs_inc[k], v);
            chk("hs_sin", hs_sin[k], sin_hist[cap]);
            chk("hs_cos", hs_cos[k], cos_hist[cap]);
        end
        chk("we_count", we_c.size(), n);
        if (done_c.size() > 0) chk("done_cycle", done_c[0], e);
        for (int c = t; c < e; c++) if (!busy_hist[c]) busy_ok = 0;
        chk("busy_window", busy_ok, 1);
        chk("busy_at_done", busy_hist[e], 0);
    endtask

    task automatic finish_sweep(int t, logic [27:0] si, logic [27:0] st, int n, int s);
        int budget = n * (s + 3) * 8 + 400;
        while (done_c.size() == 0 && cyc - t < budget) tick();
        scramble = 0; START = 1'b0;
        chk("done_seen", done_c.size(), 1);
        check_sweep(t, si, st, n, s);
        tick();
        chk("done_pulse", {DONE, BUSY, PHASE_INCREMENT_WE}, 0);
    endtask

    initial begin
        int          t, n, s;
        logic [27:0] si, st;
        RESET = 1'b1; CE = 1'b1; START = 1'b0; ABORT = 1'b0; RESULT_READY = 1'b1;
        START_INC = '0; STEP_INC = '0; STEP_COUNT = '0; SETTLE_CYCLES = '0;
        SIN_MUL_ACC = '0; COS_MUL_ACC = '0;
        tick(); tick();
        chk_zero("reset");
        RESET = 1'b0;
        tick();

        start_sweep(28'd109377165, 28'd1000000, 3, 10, t);
        finish_sweep(t, 28'd109377165, 28'd1000000, 3, 10);
        if (we_c.size() == 3) begin
            chk("tp1_period", we_c[2] - we_c[1], 13);
            chk("tp1_val2", we_v[2], 28'd111377165);
        end

        start_sweep(28'd4242, 28'd17, 2, 0, t);
        finish_sweep(t, 28'd4242, 28'd17, 2, 0);
        if (we_c.size() == 2) chk("settle0_period", we_c[1] - we_c[0], 3);

        rdy_mode = 2;
        start_sweep(28'd7, 28'd9, 3, 5, t);
        finish_sweep(t, 28'd7, 28'd9, 3, 5);
        if (we_c.size() == 3 && hs_c.size() == 3) chk("ready_hold", hs_c[1] - we_c[1], 28);
        rdy_mode = 0;

        start_sweep(28'hFFFFFF0, 28'h20, 2, 1, t);
        finish_sweep(t, 28'hFFFFFF0, 28'h20, 2, 1);
        if (we_v.size() == 2) chk("wrap", we_v[1], 28'h0000010);

        // abort in SETTLE of point 1
        start_sweep(28'd1000, 28'd77, 3, 10, t);
        for (int i = 0; i < 100 && we_c.size() < 2; i++) tick();
        chk("abort_reach", we_c.size(), 2);
        tick(); tick(); tick();
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        chk("abort_state", {BUSY, RESULT_VALID, DONE, PHASE_INCREMENT_WE}, 0);
        chk("abort_inc_hold", PHASE_INCREMENT_OUT, 28'd1077);
        repeat (5) tick();
        chk("abort_no_done", done_c.size(), 0);
        chk("abort_no_we", we_c.size(), 2);

        // abort coinciding with a handshake
        rdy_mode = 3;
        start_sweep(28'd500, 28'd3, 2, 1, t);
        for (int i = 0; i < 50 && !RESULT_VALID; i++) tick();
        chk("abort_hs_reach", RESULT_VALID, 1);
        ABORT = 1'b1; rdy_mode = 0; tick(); ABORT = 1'b0;
        chk("abort_hs_state", {BUSY, RESULT_VALID, DONE, PHASE_INCREMENT_WE}, 0);
        chk("abort_hs_inc", PHASE_INCREMENT_OUT, 28'd500);
        repeat (5) tick();
        chk("abort_hs_no_we", we_c.size(), 1);
        chk("abort_hs_no_done", done_c.size(), 0);

        ce_mode = 1;
        start_sweep(28'd100, 28'd50, 2, 3, t);
        finish_sweep(t, 28'd100, 28'd50, 2, 3);
        if (we_c.size() == 2) chk("ce_period", we_c[1] - we_c[0], 12);
        ce_mode = 0;

        start_sweep(28'd5, 28'd5, 0, 2, t);
        chk("count0", {BUSY, PHASE_INCREMENT_WE}, 0);
        tick();
        chk("count0_idle", BUSY, 0);

        rdy_mode = 3;
        start_sweep(28'h123, 28'd5, 2, 2, t);
        for (int i = 0; i < 50 && !RESULT_VALID; i++) tick();
        chk("reset_reach", RESULT_VALID, 1);
        RESET = 1'b1; tick(); RESET = 1'b0;
        chk_zero("reset_mid");
        rdy_mode = 0;
        tick();

        for (int r = 0; r < 8; r++) begin
            si = 28'($urandom); st = 28'($urandom);
            n = $urandom_range(1, 4); s = $urandom_range(0, 6);
            rdy_mode = $urandom_range(0, 1); ce_mode = $urandom_range(0, 2);
            start_sweep(si, st, n, s, t);
            scramble = 1;
            finish_sweep(t, si, st, n, s);
            ce_mode = 0; rdy_mode = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frontend_sweep_controller.md
# frontend_sweep_controller

Sequencer for the ADC/DAC frontend. It steps the DCO phase increment through a programmed list of points. At each point it waits a settle interval, then captures the filtered SIN/COS mul-acc results and hands them out through a valid/ready port. It sits between the control/host register block and the frontend's PHASE_INCREMENT_IN port, and is used for resonance sweeps before the frontend is closed into tracking.

## Interface
Parameters:
- PHASE_INCREMENT_BITS, 28, width of phase increment words
- RESULT_MUL_ACC_WIDTH, 36, width of frontend SIN/COS accumulator results
- SETTLE_BITS, 16, width of settle-cycle counter
- STEP_COUNT_BITS, 10, width of point count and index

Ports:
- CLK  in  1  clock
- RESET  in  1  reset; synchronous, active-high; one clock; overrides CE
- CE  in  1  clock enable; when low, all state and outputs hold and PHASE_INCREMENT_WE is 0
- START  in  1  start sweep; sampled in IDLE only
- ABORT  in  1  cancel sweep
- START_INC  in  PHASE_INCREMENT_BITS  first-point phase increment
- STEP_INC  in  PHASE_INCREMENT_BITS  per-point increment delta, unsigned
- STEP_COUNT  in  STEP_COUNT_BITS  number of points
- SETTLE_CYCLES  in  SETTLE_BITS  CE cycles to wait after each load
- PHASE_INCREMENT_OUT  out  PHASE_INCREMENT_BITS  to frontend PHASE_INCREMENT_IN
- PHASE_INCREMENT_WE  out  1  one-cycle write strobe
- SIN_MUL_ACC, COS_MUL_ACC  in  RESULT_MUL_ACC_WIDTH signed  frontend results
- RESULT_VALID  out  1  result available
- RESULT_READY  in  1  consumer accepts
- RESULT_SIN, RESULT_COS  out  RESULT_MUL_ACC_WIDTH signed  captured values
- RESULT_INC  out  PHASE_INCREMENT_BITS  increment the result belongs to
- RESULT_INDEX  out  STEP_COUNT_BITS  point index, 0-based
- BUSY  out  1  not IDLE
- DONE  out  1  one-cycle pulse after the last point is accepted

## Operation
- State machine: IDLE, LOAD, SETTLE, CAPTURE, OUTPUT. Transitions occur only on CE=1 cycles.
- IDLE:
  - START=1 with STEP_COUNT≠0 latches START_INC, STEP_INC, STEP_COUNT and SETTLE_CYCLES, clears the index, and moves to LOAD.
  - START with STEP_COUNT=0 is ignored.
- LOAD:
  - PHASE_INCREMENT_OUT is the current increment; PHASE_INCREMENT_WE=1 for this cycle.
  - The settle counter is loaded with the latched SETTLE_CYCLES.
  - Next state is SETTLE, or CAPTURE if SETTLE_CYCLES=0.
- SETTLE: the counter decrements each CE cycle; at 1 the next state is CAPTURE. The state lasts exactly SETTLE_CYCLES CE cycles.
- CAPTURE: register SIN_MUL_ACC, COS_MUL_ACC, the current increment and the index into the RESULT_* outputs; go to OUTPUT.
- OUTPUT:
  - RESULT_VALID=1. RESULT_* values are stable until the handshake (RESULT_VALID & RESULT_READY & CE).
  - On a handshake at the last point (index = STEP_COUNT-1): DONE=1 next cycle, go to IDLE.
  - On a handshake at any other point: index+1, increment += STEP_INC modulo 2^PHASE_INCREMENT_BITS (wraps, no saturation), go to LOAD.
- PHASE_INCREMENT_OUT holds its last written value in all states, including after abort and DONE.
- ABORT=1 on a CE cycle in any non-IDLE state moves to IDLE next cycle.
  - RESULT_VALID drops and no DONE is issued.
  - ABORT has priority over a simultaneous handshake; that result counts as not accepted.
- START while BUSY is ignored. Input changes during a sweep have no effect.

## Timing
- Reset values: state IDLE; PHASE_INCREMENT_OUT, PHASE_INCREMENT_WE, RESULT_VALID, RESULT_SIN, RESULT_COS, RESULT_INC, RESULT_INDEX, BUSY and DONE are all 0. Reset mid-sweep aborts immediately, with no DONE.
- With START accepted at edge t and CE held high:
  - WE is high during cycle t+1.
  - CAPTURE occurs at t+2+SETTLE_CYCLES.
  - RESULT_VALID rises at t+3+SETTLE_CYCLES.
- Per-point period with READY held high is SETTLE_CYCLES+3 cycles.
- BUSY=1 from the cycle after START until the cycle DONE asserts. DONE and BUSY=0 coincide, and DONE lasts one cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- START_INC=109377165, STEP_INC=1000000, STEP_COUNT=3, SETTLE_CYCLES=10, READY=1 -> three WE pulses 13 cycles apart with values 109377165, 110377165, 111377165; results with indices 0,1,2; DONE one cycle after the third handshake.
- SETTLE_CYCLES=0, STEP_COUNT=2 -> RESULT_VALID 2 cycles after each WE; period 3 cycles.
- READY held low 20 cycles at point 1 -> RESULT_* stable, no next WE until READY rises.
- START_INC=0x FFFFFF0, STEP_INC=0x20, STEP_COUNT=2 -> second increment 0x0000010 (wrap).
- ABORT during SETTLE of point 1, and separately ABORT coinciding with a handshake -> IDLE next cycle, VALID=0, no DONE, PHASE_INCREMENT_OUT keeps the last value.
- CE toggled 1/0 every cycle -> all intervals doubled in clocks, no WE while CE=0. START with STEP_COUNT=0 -> BUSY stays 0. RESET asserted mid-OUTPUT -> all outputs 0 next cycle.
